row_max_ctrl: RTL and testbench

Sequencer that computes the signed maximum of one attention-score row of up to MAX_CHUNKS×16 elements, ahead of the softmax exponent stage. It fetches the row one 16-element chunk at a time over a request/valid read port and feeds each chunk to one instance of the 16-input max-tree unit `sel_max`. It folds each chunk result into a running maximum and reports the row maximum with a one-cycle done pulse.

---
 rtl/mha_pkg.sv | 26 ++
 rtl/sel_max.sv | 62 ++++++
 rtl/row_max_ctrl.sv | 145 ++++++++++++++
 tb/tb_row_max_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mha_pkg.sv
// Shared definitions for the attention-score row blocks.
//   ELEM_W   : element width (signed two's complement)
//   CHUNK_SZ : elements delivered per read beat
//   MIN_VAL  : most negative ELEM_W value, the identity for a signed max
//   state_t  : row sequencer states
//   signed_max(a, b) : larger of a and b as signed values; returns a on a tie
package mha_pkg;

    localparam int ELEM_W   = 16;
    localparam int CHUNK_SZ = 16;

    localparam logic [ELEM_W-1:0] MIN_VAL = {1'b1, {(ELEM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [ELEM_W-1:0] signed_max(input logic [ELEM_W-1:0] a,
                                                     input logic [ELEM_W-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

endpackage

// File: rtl/sel_max.sv
// 16-input pipelined signed max tree (16 -> 8 -> 4 -> 2 -> 1).
// An enable accepted in cycle t produces O_VLD (one-cycle pulse) and O_MAX
// in cycle t+4. The enable is only accepted while no operand set is in
// flight; O_BUSY reports that.
//   I_CLK    : clock, rising edge
//   I_RST_N  : asynchronous active-low reset
//   I_EN     : operand enable; sampled only when idle
//   I_DATA   : CHUNK_SZ elements, element i at [i*ELEM_W +: ELEM_W]
//   O_BUSY   : an operand set is in the pipeline
//   O_VLD    : result valid pulse
//   O_MAX    : signed maximum of the accepted operand set
module sel_max
    import mha_pkg::*;
(
    input  logic                         I_CLK,
    input  logic                         I_RST_N,
    input  logic                         I_EN,
    input  logic [CHUNK_SZ*ELEM_W-1:0]   I_DATA,
    output logic                         O_BUSY,
    output logic                         O_VLD,
    output logic [ELEM_W-1:0]            O_MAX
);

    logic [3:0]              vld_pipe;
    logic                    accept;
    logic [ELEM_W-1:0]       s1 [8];
    logic [ELEM_W-1:0]       s2 [4];
    logic [ELEM_W-1:0]       s3 [2];
    logic [ELEM_W-1:0]       s4;

    assign O_BUSY = |vld_pipe;
    assign accept = I_EN && !O_BUSY;
    assign O_VLD  = vld_pipe[3];
    assign O_MAX  = s4;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:0], accept};
        end
    end

    // Data stages carry no reset: they are only observed alongside vld_pipe.
    // Stage 1 holds its operands unless a new set is accepted.
    always_ff @(posedge I_CLK) begin
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                s1[i] <= signed_max(I_DATA[(2*i)*ELEM_W +: ELEM_W],
                                    I_DATA[(2*i+1)*ELEM_W +: ELEM_W]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            s2[i] <= signed_max(s1[2*i], s1[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            s3[i] <= signed_max(s2[2*i], s2[2*i+1]);
        end
        s4 <= signed_max(s3[0], s3[1]);
    end

endmodule

// File: rtl/row_max_ctrl.sv
// Row maximum sequencer: fetches a row of up to MAX_CHUNKS*16 signed
// elements chunk by chunk, reduces each chunk with sel_max and folds the
// chunk results into a running maximum. O_DONE pulses for one cycle with
// O_ROW_MAX already holding the row result.
//   I_CLK, I_RST_N  : clock (rising edge), asynchronous active-low reset
//   I_START         : start-row pulse, sampled in S_IDLE only
//   I_NUM_CHUNKS    : chunk count, sampled with I_START, clamped to MAX_CHUNKS
//   O_BUSY          : high in every state except S_IDLE
//   O_RD_REQ/O_RD_IDX, I_RD_VLD/I_RD_DATA : chunk read port
//   O_DONE          : one-cycle row-complete pulse
//   O_ROW_MAX       : row maximum, held until the next O_DONE
//   O_DBG_STATE     : current sequencer state
//
// Read handshake: O_RD_REQ is raised with O_RD_IDX and both stay stable
// until a cycle in which I_RD_VLD is high; that cycle transfers I_RD_DATA
// (I_RD_VLD may already be high in the first request cycle). I_RD_VLD in
// any cycle without O_RD_REQ carries no data and is ignored.
module row_max_ctrl
    import mha_pkg::*;
#(
    parameter int D_W        = ELEM_W,
    parameter int MAX_CHUNKS = 8,
    parameter int CW         = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                    I_CLK,
    input  logic                    I_RST_N,
    input  logic                    I_START,
    input  logic [CW-1:0]           I_NUM_CHUNKS,
    output logic                    O_BUSY,
    output logic                    O_RD_REQ,
    output logic [CW-1:0]           O_RD_IDX,
    input  logic                    I_RD_VLD,
    input  logic [CHUNK_SZ*D_W-1:0] I_RD_DATA,
    output logic                    O_DONE,
    output logic [D_W-1:0]          O_ROW_MAX,
    output logic [1:0]              O_DBG_STATE
);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_idx;
    logic [CW-1:0]   num_clamped;
    logic [D_W-1:0]  run_max;
    logic [D_W-1:0]  run_upd;
    logic [D_W-1:0]  row_max;
    logic            last_chunk;
    logic            sub_en;
    logic            sub_vld;
    logic            sub_busy;
    logic [D_W-1:0]  sub_max;

    assign num_clamped = (I_NUM_CHUNKS > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : I_NUM_CHUNKS;
    assign last_chunk  = (rd_idx == count - CW'(1));
    assign run_upd     = signed_max(run_max, sub_max);

    // One enable per chunk: only the transfer cycle of the read handshake.
    // sel_max is always idle here because S_WAIT is left on its result pulse.
    assign sub_en      = (state == S_FETCH) && I_RD_VLD;

    assign O_BUSY      = (state != S_IDLE);
    assign O_RD_REQ    = (state == S_FETCH);
    assign O_DONE      = (state == S_DONE);
    assign O_RD_IDX    = rd_idx;
    assign O_ROW_MAX   = row_max;
    assign O_DBG_STATE = state;

    sel_max u_sel_max (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_EN    (sub_en),
        .I_DATA  (I_RD_DATA),
        .O_BUSY  (sub_busy),
        .O_VLD   (sub_vld),
        .O_MAX   (sub_max)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (I_START) begin
                    state_nxt = (num_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (I_RD_VLD) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sub_vld) begin
                    state_nxt = last_chunk ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state   <= S_IDLE;
            count   <= '0;
            rd_idx  <= '0;
            run_max <= MIN_VAL;
            row_max <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (I_START) begin
                        count   <= num_clamped;
                        rd_idx  <= '0;
                        run_max <= MIN_VAL;
                    end
                end
                S_WAIT: begin
                    if (sub_vld) begin
                        run_max <= run_upd;
                        if (!last_chunk) begin
                            rd_idx <= rd_idx + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            // Result is registered on the way into S_DONE so it is already
            // visible in the O_DONE cycle. An empty row reports MIN_VAL.
            if (state != S_DONE && state_nxt == S_DONE) begin
                row_max <= (state == S_IDLE) ? MIN_VAL : run_upd;
            end
        end
    end

    // sel_max busy is implied by the FSM being in S_WAIT; kept for visibility.
    logic unused_ok;
    assign unused_ok = sub_busy;

endmodule

// File: tb/tb_row_max_ctrl.sv
// Directed + randomized bench for row_max_ctrl. Expected row maxima, read
// counts and done cycles come from a plain array model of the row.
module tb_row_max_ctrl;

    localparam int D_W        = 16;
    localparam int MAX_CHUNKS = 8;
    localparam int CW         = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 I_START = 1'b0;
    logic [CW-1:0]        I_NUM_CHUNKS = '0;
    logic                 O_BUSY;
    logic                 O_RD_REQ;
    logic [CW-1:0]        O_RD_IDX;
    logic                 I_RD_VLD = 1'b0;
    logic [16*D_W-1:0]    I_RD_DATA = '0;
    logic                 O_DONE;
    logic [D_W-1:0]       O_ROW_MAX;
    logic [1:0]           O_DBG_STATE;

    logic [D_W-1:0]       row_data [MAX_CHUNKS*16];
    int                   total = 0;
    int                   bad = 0;

    always #5 clk = ~clk;

    row_max_ctrl #(.D_W(D_W), .MAX_CHUNKS(MAX_CHUNKS), .CW(CW)) dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_START      (I_START),
        .I_NUM_CHUNKS (I_NUM_CHUNKS),
        .O_BUSY       (O_BUSY),
        .O_RD_REQ     (O_RD_REQ),
        .O_RD_IDX     (O_RD_IDX),
        .I_RD_VLD     (I_RD_VLD),
        .I_RD_DATA    (I_RD_DATA),
        .O_DONE       (O_DONE),
        .O_ROW_MAX    (O_ROW_MAX),
        .O_DBG_STATE  (O_DBG_STATE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chunk k gets maxv at a random slot and values <= maxv elsewhere.
    task automatic fill_chunk_max(input int k, input logic [D_W-1:0] maxv);
        int mx;
        int off;
        mx = $signed(maxv);
        for (int e = 0; e < 16; e++) begin
            off = int'($urandom_range(0, mx + 32768));
            row_data[k*16+e] = 16'(off - 32768);
        end
        row_data[k*16 + int'($urandom_range(0, 15))] = maxv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAX_CHUNKS*16; i++) begin
            row_data[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    // Runs one row. stall_chunk/stall_len delay I_RD_VLD for one chunk,
    // busy_start_at pulses I_START at that cycle, abort_chunk >= 0 returns
    // right after driving that chunk's read data (caller then resets).
    task automatic run_row(input int n, input int stall_chunk, input int stall_len,
                           input int busy_start_at, input int abort_chunk);
        int nc;
        int exp_max;
        int exp_done;
        int acc;
        int stall_left;
        int done_at;
        int v;
        logic [D_W-1:0] em;

        nc = (n > MAX_CHUNKS) ? MAX_CHUNKS : n;
        exp_max = -32768;
        for (int k = 0; k < nc; k++) begin
            for (int e = 0; e < 16; e++) begin
                v = $signed(row_data[k*16+e]);
                if (v > exp_max) exp_max = v;
            end
        end
        em = 16'(exp_max);
        exp_done = 5*nc + 1 + ((stall_chunk >= 0 && stall_chunk < nc) ? stall_len : 0);
        acc = 0;
        stall_left = stall_len;
        done_at = -1;

        @(negedge clk);
        I_START = 1'b1;
        I_NUM_CHUNKS = CW'(n);
        I_RD_VLD = 1'b0;
        for (int c = 1; c <= exp_done + 20; c++) begin
            @(negedge clk);
            I_START = (c == busy_start_at);
            if (c == busy_start_at) I_NUM_CHUNKS = CW'($urandom_range(0, 15));
            if (O_DONE) begin
                done_at = c;
                break;
            end
            if (O_RD_REQ) begin
                check("rd_idx", 32'(O_RD_IDX), 32'(acc));
                if (acc == stall_chunk && stall_left > 0) begin
                    I_RD_VLD = 1'b0;
                    stall_left--;
                end else begin
                    I_RD_VLD = 1'b1;
                    for (int e = 0; e < 16; e++) begin
                        I_RD_DATA[e*D_W +: D_W] = row_data[(acc % MAX_CHUNKS)*16 + e];
                    end
                    acc++;
                    if (acc - 1 == abort_chunk) return;
                end
            end else begin
                // Stray valid with junk data outside a request must be ignored.
                I_RD_VLD = 1'($urandom_range(0, 1));
                for (int e = 0; e < 16; e++) begin
                    I_RD_DATA[e*D_W +: D_W] = 16'($urandom_range(0, 65535));
                end
            end
        end

        if (done_at < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_cycle", 32'(done_at), 32'(exp_done));
            check("row_max", 32'(O_ROW_MAX), 32'(em));
            check("read_count", 32'(acc), 32'(nc));
            // Start in the O_DONE cycle must not be taken.
            I_START = 1'b1;
            I_NUM_CHUNKS = 4'd3;
            I_RD_VLD = 1'b0;
            @(negedge clk);
            I_START = 1'b0;
            check("done_pulse_len", 32'(O_DONE), 32'd0);
            check("idle_after_done", 32'(O_BUSY), 32'd0);
            check("row_max_hold", 32'(O_ROW_MAX), 32'(em));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(O_BUSY), 32'd0);
        check({tag, "_req"}, 32'(O_RD_REQ), 32'd0);
        check({tag, "_done"}, 32'(O_DONE), 32'd0);
        check({tag, "_idx"}, 32'(O_RD_IDX), 32'd0);
    endtask

    initial begin
        int quiet_bad;
        int n;
        int sc;

        // Reset values, then 20 idle cycles without I_START.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_idle_outputs("reset_idle");
            check("reset_row_max", 32'(O_ROW_MAX), 32'd0);
        end

        // Single chunk, peak 0x0100 at element 9.
        for (int e = 0; e < 16; e++) row_data[e] = 16'h0001;
        row_data[0] = 16'h0003;
        row_data[1] = 16'hFFF0;
        row_data[9] = 16'h0100;
        run_row(1, -1, 0, 0, -1);
        check("single_chunk_max", 32'(O_ROW_MAX), 32'h0100);

        // Four all-negative chunks.
        fill_chunk_max(0, 16'hFF00);
        fill_chunk_max(1, 16'hFFFE);
        fill_chunk_max(2, 16'h8001);
        fill_chunk_max(3, 16'hFFF0);
        run_row(4, -1, 0, 0, -1);
        check("neg_rows_max", 32'(O_ROW_MAX), 32'hFFFE);

        // Two chunks, chunk 1 stalled 3 cycles, start pulsed while busy.
        fill_random();
        run_row(2, 1, 3, 3, -1);

        // Empty row.
        run_row(0, -1, 0, 0, -1);
        check("empty_row_max", 32'(O_ROW_MAX), 32'h8000);

        // Oversized count clamps to MAX_CHUNKS reads.
        fill_random();
        run_row(12, -1, 0, 0, -1);

        // Reset while waiting on chunk 2 of 4.
        fill_random();
        run_row(4, -1, 0, 0, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        I_RD_VLD = 1'b0;
        I_START = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_row_max", 32'(O_ROW_MAX), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (O_RD_REQ || O_DONE || O_BUSY) quiet_bad++;
        end
        check("quiet_after_abort", 32'(quiet_bad), 32'd0);

        // Fresh row after the abort.
        fill_chunk_max(0, 16'h0005);
        run_row(1, -1, 0, 0, -1);
        check("fresh_row_max", 32'(O_ROW_MAX), 32'h0005);

        // Randomized rows with random stalls.
        for (int r = 0; r < 12; r++) begin
            fill_random();
            n = int'($urandom_range(0, 10));
            sc = int'($urandom_range(0, 8));
            run_row(n, sc, int'($urandom_range(0, 4)), int'($urandom_range(0, 1)) * 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
